// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end feeding one shared binary-to-Gray
// converter. Each accepted operand walks IDLE -> CONV -> HOLD and the result
// is held in HOLD until the consumer takes it.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_id,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opnd;
  logic             r_own;
  logic             r_last;
  logic             r_valid;
  logic [WIDTH-1:0] r_gray;
  logic             r_out_id;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [WIDTH-1:0] w_gray;

  // Grants only exist in IDLE; with both requesting, the one not served last wins.
  // rst_n gating keeps grants low while reset is held even though state reads IDLE.
  assign w_idle = rst_n && (r_state == IDLE);
  assign w_gnt0 = w_idle && req0 && (!req1 || r_last);
  assign w_gnt1 = w_idle && req1 && (!req0 || !r_last);
  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;

  // Shared converter on the captured operand: MSB passes, lower bits XOR their upper neighbour.
  always_comb begin
    w_gray = '0;
    w_gray[WIDTH-1] = r_opnd[WIDTH-1];
    for (int i = 0; i < WIDTH-1; i++) begin
      w_gray[i] = r_opnd[i+1] ^ r_opnd[i];
    end
  end

  // Control FSM with registered result outputs; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_opnd   <= '0;
      r_own    <= 1'b0;
      r_last   <= 1'b1;
      r_valid  <= 1'b0;
      r_gray   <= '0;
      r_out_id <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_opnd  <= w_gnt1 ? bin1 : bin0;
            r_own   <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_gray   <= w_gray;
          r_out_id <= r_own;
          r_valid  <= 1'b1;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_gray  = r_gray;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: a vector table, hand-written corner sequences
// (stall, reset in CONV/HOLD, round-robin, full sweep) and a randomized run
// against a transaction-level reference model.
module tb_gray_conv_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
  logic [W-1:0] bin0 = '0, bin1 = '0;
  logic         gnt0, gnt1, out_valid, out_id;
  logic [W-1:0] out_gray;

  int n_chk = 0;
  int n_pass = 0;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .bin0(bin0), .gnt0(gnt0),
    .req1(req1), .bin1(bin1), .gnt1(gnt1),
    .out_valid(out_valid), .out_gray(out_gray), .out_id(out_id),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r0;
    logic [W-1:0] b0;
    logic         r1;
    logic [W-1:0] b1;
    logic         eg0;
    logic         eg1;
    logic [W-1:0] egray;
    logic         eid;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // advance one full clock, ending on the falling edge
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // reference model state (transaction level)
  bit           m_busy;
  int           m_age;
  logic [W-1:0] m_gray;
  logic         m_id;
  logic         m_last;

  initial begin
    bit eg0, eg1, ev;

    // vectors applied in order from reset; round-robin history is baked in
    tbl[0] = '{1'b1, 4'b1011, 1'b0, 4'd0,  1'b1, 1'b0, 4'b1110, 1'b0};
    tbl[1] = '{1'b1, 4'd9,    1'b1, 4'd6,  1'b0, 1'b1, 4'b0101, 1'b1};
    tbl[2] = '{1'b1, 4'd9,    1'b1, 4'd6,  1'b1, 1'b0, 4'b1101, 1'b0};
    tbl[3] = '{1'b0, 4'd0,    1'b1, 4'd15, 1'b0, 1'b1, 4'b1000, 1'b1};
    tbl[4] = '{1'b0, 4'd7,    1'b1, 4'd0,  1'b0, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 4'd8,    1'b1, 4'd3,  1'b1, 1'b0, 4'b1100, 1'b0};
    tbl[6] = '{1'b1, 4'd5,    1'b0, 4'd9,  1'b1, 1'b0, 4'b0111, 1'b0};

    // reset state
    req0 = 1'b1; req1 = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_gray", out_gray, 0);
    chk("rst_id", out_id, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    do_reset;

    // table: one full transaction per row, out_ready held high throughout
    foreach (tbl[i]) begin
      req0 = tbl[i].r0; bin0 = tbl[i].b0;
      req1 = tbl[i].r1; bin1 = tbl[i].b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].eg0);
      chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].eg1);
      tick;
      req0 = 1'b0; req1 = 1'b0;
      bin0 = ~bin0; bin1 = ~bin1; // ungranted bin changes must not matter
      #1;
      chk($sformatf("tbl%0d_conv_valid", i), out_valid, 0);
      tick;
      #1;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_gray", i), out_gray, tbl[i].egray);
      chk($sformatf("tbl%0d_id", i), out_id, tbl[i].eid);
      tick;
      #1;
      chk($sformatf("tbl%0d_idle_valid", i), out_valid, 0);
    end

    // round-robin from reset, both requests held: 0,1,0 with one result per 3 clocks
    do_reset;
    req0 = 1'b1; bin0 = 4'd9; req1 = 1'b1; bin1 = 4'd6; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      eg0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      eg1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      ev  = (c % 3 == 2);
      chk($sformatf("rr%0d_gnt0", c), gnt0, eg0);
      chk($sformatf("rr%0d_gnt1", c), gnt1, eg1);
      chk($sformatf("rr%0d_valid", c), out_valid, ev);
      if (ev) begin
        chk($sformatf("rr%0d_gray", c), out_gray, ((c / 3) % 2 == 0) ? 4'b1101 : 4'b0101);
        chk($sformatf("rr%0d_id", c), out_id, (c / 3) % 2);
      end
      tick;
    end

    // stall in HOLD for 5 cycles with requests pending
    do_reset;
    req1 = 1'b1; bin1 = 4'd15; out_ready = 1'b0;
    #1 chk("hold_gnt1", gnt1, 1);
    tick;
    req1 = 1'b0;
    tick;
    req0 = 1'b1; bin0 = 4'd2; req1 = 1'b1; bin1 = 4'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_gray", out_gray, 4'b1000);
      chk("hold_id", out_id, 1);
      chk("hold_gnt0", gnt0, 0);
      chk("hold_gnt1", gnt1, 0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    #1 chk("hold_rel_gnt0", gnt0, 1);
    chk("hold_rel_gnt1", gnt1, 0);
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    #1 chk("hold_next_gray", out_gray, 4'b0011);
    chk("hold_next_id", out_id, 0);
    tick;

    // asynchronous reset while holding a result
    req0 = 1'b1; bin0 = 4'b1011; out_ready = 1'b0;
    tick;
    req0 = 1'b0;
    tick;
    #1 chk("rh_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; bin0 = 4'd3; bin1 = 4'd12;
    #1;
    chk("rh_valid", out_valid, 0);
    chk("rh_gray", out_gray, 0);
    chk("rh_gnt0", gnt0, 0);
    chk("rh_gnt1", gnt1, 0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    chk("rh_first_gnt0", gnt0, 1);
    chk("rh_first_gnt1", gnt1, 0);
    chk("rh_rel_valid", out_valid, 0);
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    #1 chk("rh_new_gray", out_gray, 4'b0010);
    chk("rh_new_id", out_id, 0);
    out_ready = 1'b1;
    tick;

    // asynchronous reset during CONV: pending result dropped
    req1 = 1'b1; bin1 = 4'd5;
    #1 chk("rc_gnt1", gnt1, 1);
    tick;
    req1 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rc_valid", out_valid, 0);
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("rc_no_valid", out_valid, 0);
      tick;
    end

    // full sweep through requester 0
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      req0 = 1'b1; bin0 = W'(v);
      #1 chk($sformatf("sw%0d_gnt0", v), gnt0, 1);
      tick;
      req0 = 1'b0;
      tick;
      #1 chk($sformatf("sw%0d_gray", v), out_gray, to_gray(W'(v)));
      tick;
    end

    // randomized run against the transaction model
    do_reset;
    m_busy = 0; m_age = 0; m_gray = '0; m_id = 0; m_last = 1;
    for (int c = 0; c < 600; c++) begin
      req0 = 1'($urandom % 2); req1 = 1'($urandom % 2);
      bin0 = W'($urandom); bin1 = W'($urandom);
      out_ready = ($urandom % 3) != 0;
      #1;
      eg0 = !m_busy && req0 && (!req1 || m_last == 1'b1);
      eg1 = !m_busy && req1 && (!req0 || m_last == 1'b0);
      ev  = m_busy && m_age >= 2;
      chk("rnd_gnt0", gnt0, eg0);
      chk("rnd_gnt1", gnt1, eg1);
      chk("rnd_valid", out_valid, ev);
      if (ev) begin
        chk("rnd_gray", out_gray, m_gray);
        chk("rnd_id", out_id, m_id);
      end
      // what the coming edge does
      if (!m_busy) begin
        if (eg0 || eg1) begin
          m_busy = 1; m_age = 1;
          m_id = eg1; m_last = eg1;
          m_gray = to_gray(eg1 ? bin1 : bin0);
        end
      end else if (m_age >= 2 && out_ready) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
